// File: rtl/alu_writeback_rf.sv
// alu_writeback_rf
// Write-back end of the 3-stage ALU pipeline. Each issued R-type/I-type
// instruction's destination travels down a tag shift register that mirrors
// the ALU pipeline depth. When the tag reaches the commit stage, the value on
// alu_result is written into a 32 x XLEN register file.
//
// Ports:
//   clk               - single clock, all state changes on the rising edge
//   reset             - synchronous, active-high reset
//   issue_valid       - issue_instruction is valid this cycle
//   issue_instruction - instruction word entering the ALU pipeline
//   alu_result        - registered result output of the ALU pipeline
//   rs1_addr/rs2_addr - read-port addresses
//   rs1_data/rs2_data - combinational read data, bypassing the commit stage
//   hazard            - combinational RAW hazard flag for the issuing word
//   wb_valid/wb_rd/wb_data - registered record of last cycle's commit
//   retire_count      - registered count of retired ALU instructions
module alu_writeback_rf #(
  parameter int XLEN       = 32,
  parameter int WB_LATENCY = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [31:0]     issue_instruction,
  input  logic [XLEN-1:0] alu_result,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            hazard,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [31:0]     retire_count
);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  // Issue decode
  logic [6:0] opcode;
  logic       is_r;
  logic       is_i;
  logic       new_valid;
  logic       new_we;
  logic [4:0] new_rd;
  logic [4:0] src1;
  logic [4:0] src2;

  assign opcode    = issue_instruction[6:0];
  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign new_valid = issue_valid && (is_r || is_i);
  assign new_rd    = issue_instruction[11:7];
  assign new_we    = new_valid && (new_rd != 5'd0);
  assign src1      = issue_instruction[19:15];
  assign src2      = issue_instruction[24:20];

  // funct fields and upper immediate bits play no part in write-back
  logic unused_bits;
  assign unused_bits = ^{issue_instruction[31:25], issue_instruction[14:12]};

  // Tag pipe: stage 0 holds the instruction issued last cycle, the last
  // stage is the commit stage whose result is on alu_result right now.
  logic [WB_LATENCY-1:0] tag_valid_q;
  logic [WB_LATENCY-1:0] tag_we_q;
  logic [4:0]            tag_rd_q [WB_LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_q[0] <= 1'b0;
      tag_we_q[0]    <= 1'b0;
      tag_rd_q[0]    <= 5'd0;
    end else begin
      tag_valid_q[0] <= new_valid;
      tag_we_q[0]    <= new_we;
      tag_rd_q[0]    <= new_rd;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < WB_LATENCY; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (reset) begin
          tag_valid_q[gi] <= 1'b0;
          tag_we_q[gi]    <= 1'b0;
          tag_rd_q[gi]    <= 5'd0;
        end else begin
          tag_valid_q[gi] <= tag_valid_q[gi-1];
          tag_we_q[gi]    <= tag_we_q[gi-1];
          tag_rd_q[gi]    <= tag_rd_q[gi-1];
        end
      end
    end
  endgenerate

  logic       commit_valid;
  logic       commit_we;
  logic [4:0] commit_rd;

  assign commit_valid = tag_valid_q[WB_LATENCY-1];
  assign commit_we    = tag_we_q[WB_LATENCY-1];
  assign commit_rd    = tag_rd_q[WB_LATENCY-1];

  // Register file. Full reset clears every entry, so it lives in flops.
  // we is never set for rd=0, which keeps x0 permanently zero.
  logic [XLEN-1:0] rf_q [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (commit_we) begin
      rf_q[commit_rd] <= alu_result;
    end
  end

  // Write-back record and retire counter
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [31:0]     retire_count_q, retire_count_d;

  always_comb begin
    wb_valid_d     = commit_we;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    retire_count_d = retire_count_q;
    if (commit_we) begin
      wb_rd_d   = commit_rd;
      wb_data_d = alu_result;
    end
    // Writes to x0 still retire; the counter wraps naturally at 2^32.
    if (commit_valid) begin
      retire_count_d = retire_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_data_q      <= '0;
      retire_count_q <= 32'd0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign retire_count = retire_count_q;

  // Read ports with bypass of the value being committed this cycle
  always_comb begin
    rs1_data = rf_q[rs1_addr];
    if (rs1_addr == 5'd0) begin
      rs1_data = '0;
    end else if (commit_we && (commit_rd == rs1_addr)) begin
      rs1_data = alu_result;
    end
  end

  always_comb begin
    rs2_data = rf_q[rs2_addr];
    if (rs2_addr == 5'd0) begin
      rs2_data = '0;
    end else if (commit_we && (commit_rd == rs2_addr)) begin
      rs2_data = alu_result;
    end
  end

  // RAW hazard against in-flight writers. The commit stage is excluded since
  // the bypass already delivers its value. rs2 is a source only for R-type.
  logic hazard_hit;

  always_comb begin
    hazard_hit = 1'b0;
    for (int i = 0; i < WB_LATENCY - 1; i++) begin
      if (tag_we_q[i]) begin
        if ((src1 != 5'd0) && (tag_rd_q[i] == src1)) begin
          hazard_hit = 1'b1;
        end
        if (is_r && (src2 != 5'd0) && (tag_rd_q[i] == src2)) begin
          hazard_hit = 1'b1;
        end
      end
    end
  end

  assign hazard = issue_valid && (is_r || is_i) && hazard_hit;

endmodule

// File: tb/tb_alu_writeback_rf.sv
// Directed bench for alu_writeback_rf with a scoreboard of expected commits.
module tb_alu_writeback_rf;

  localparam int XLEN = 32;
  localparam int LAT  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_valid;
  logic [31:0]     issue_instruction;
  logic [XLEN-1:0] alu_result;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            hazard;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [31:0]     retire_count;

  alu_writeback_rf #(.XLEN(XLEN), .WB_LATENCY(LAT)) dut (
    .clk               (clk),
    .reset             (reset),
    .issue_valid       (issue_valid),
    .issue_instruction (issue_instruction),
    .alu_result        (alu_result),
    .rs1_addr          (rs1_addr),
    .rs2_addr          (rs2_addr),
    .rs1_data          (rs1_data),
    .rs2_data          (rs2_data),
    .hazard            (hazard),
    .wb_valid          (wb_valid),
    .wb_rd             (wb_rd),
    .wb_data           (wb_data),
    .retire_count      (retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;   // cycle in which wb_* shows this commit
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } sb_t;

  sb_t         sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_retire = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one cycle: check the commit record and drive alu_result for any
  // instruction whose commit stage is the new cycle.
  task automatic tick();
    logic rst_s;
    sb_t  e;
    rst_s = reset;
    @(posedge clk);
    cyc++;
    #1;
    issue_valid       = 1'b0;
    issue_instruction = 32'd0;
    if (rst_s) begin
      sb.delete();
      exp_retire = 32'd0;
      check("wb_valid_reset", {31'd0, wb_valid}, 32'd0);
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      exp_retire = exp_retire + 32'd1;
      check("wb_valid", {31'd0, wb_valid}, {31'd0, e.we});
      if (e.we) begin
        check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        check("wb_data", wb_data, e.data);
      end
      $display("cycle %0d commit rd=%0d we=%0b data=%h retire=%0d", cyc, e.rd, e.we, e.data, retire_count);
    end else begin
      check("wb_valid_idle", {31'd0, wb_valid}, 32'd0);
    end
    check("retire_count", retire_count, exp_retire);
    alu_result = $urandom;
    foreach (sb[i]) begin
      if (sb[i].due == cyc + 1) alu_result = sb[i].data;
    end
  endtask

  // Present an instruction this cycle; ALU-class words become expected commits.
  task automatic issue(input logic [31:0] w, input logic [31:0] result);
    sb_t e;
    issue_valid       = 1'b1;
    issue_instruction = w;
    if (w[6:0] == 7'b0110011 || w[6:0] == 7'b0010011) begin
      e.due  = cyc + LAT + 1;
      e.rd   = w[11:7];
      e.we   = (w[11:7] != 5'd0);
      e.data = result;
      sb.push_back(e);
    end
    $display("cycle %0d issue %h result %h", cyc, w, result);
  endtask

  task automatic drain();
    repeat (LAT + 2) tick();
  endtask

  initial begin
    reset             = 1'b1;
    issue_valid       = 1'b0;
    issue_instruction = 32'd0;
    alu_result        = 32'd0;
    rs1_addr          = 5'd0;
    rs2_addr          = 5'd0;

    // Reset for two cycles, then sweep both read ports
    tick();
    tick();
    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rs1_addr = a[4:0];
      rs2_addr = 5'(31 - a);
      #0.1;
      check("reset_rs1", rs1_data, 32'd0);
      check("reset_rs2", rs2_data, 32'd0);
    end
    check("reset_retire", retire_count, 32'd0);

    // Basic write-back: add x5,x1,x2
    tick();
    issue(32'h002082B3, 32'h1234_5678);
    repeat (LAT) tick();
    rs1_addr = 5'd5;
    #1;
    check("bypass_rs1_x5", rs1_data, 32'h1234_5678);
    tick();
    rs2_addr = 5'd5;
    #1;
    check("rf_rs2_x5", rs2_data, 32'h1234_5678);
    check("retire_after_add", retire_count, 32'd1);
    drain();

    // addi x0,x0,5 retires without writing
    issue(32'h00500013, 32'h0000_0005);
    repeat (LAT) tick();
    rs1_addr = 5'd0;
    #1;
    check("x0_in_commit", rs1_data, 32'd0);
    tick();
    check("x0_retire", retire_count, 32'd2);
    check("x0_wb_valid", {31'd0, wb_valid}, 32'd0);
    rs1_addr = 5'd0;
    #1;
    check("x0_read", rs1_data, 32'd0);
    drain();

    // lw x1,0(x0) is a bubble
    issue(32'h00002083, 32'hCAFE_0001);
    drain();
    check("lw_retire", retire_count, 32'd2);
    rs1_addr = 5'd1;
    #1;
    check("lw_x1", rs1_data, 32'd0);

    // Hazard window
    tick();
    issue(32'h00100193, 32'h0000_0001);     // addi x3,x0,1 (cycle 0)
    tick();
    issue(32'h00318233, 32'h0000_0002);     // add x4,x3,x3 (cycle 1)
    #1;
    check("hazard_c1", {31'd0, hazard}, 32'd1);
    tick();
    issue(32'h00300513, 32'h0000_0003);     // addi x10,x0,3 (cycle 2)
    #1;
    check("hazard_itype_rs2", {31'd0, hazard}, 32'd0);
    tick();                                 // cycle 3
    issue_valid       = 1'b0;
    issue_instruction = 32'h00318233;
    #1;
    check("hazard_no_valid", {31'd0, hazard}, 32'd0);
    issue(32'h00318233, 32'h0000_0004);
    #1;
    check("hazard_c3", {31'd0, hazard}, 32'd1);
    tick();
    issue(32'h00318233, 32'h0000_0005);     // cycle 4: x3 at commit stage
    #1;
    check("hazard_c4", {31'd0, hazard}, 32'd0);
    drain();
    rs1_addr = 5'd3;
    rs2_addr = 5'd4;
    #1;
    check("x3_value", rs1_data, 32'd1);
    check("x4_value", rs2_data, 32'd5);

    // Reset mid-flight drops add x7,x1,x2
    tick();
    issue(32'h002083B3, 32'h5555_AAAA);     // cycle 0
    tick();                                 // cycle 1
    tick();                                 // cycle 2
    reset = 1'b1;
    tick();                                 // cycle 3
    reset = 1'b0;
    tick();                                 // cycle 4
    alu_result = 32'hDEAD_BEEF;
    tick();                                 // cycle 5
    rs1_addr = 5'd7;
    rs2_addr = 5'd5;
    #1;
    check("midflight_x7", rs1_data, 32'd0);
    check("midflight_x5_cleared", rs2_data, 32'd0);
    check("midflight_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("midflight_retire", retire_count, 32'd0);
    drain();

    // Back-to-back addi x9 with results 1..4
    for (int k = 1; k <= 4; k++) begin
      tick();
      issue(32'h00100493, k);
    end
    drain();
    rs1_addr = 5'd9;
    #1;
    check("x9_final", rs1_data, 32'd4);
    check("b2b_retire", retire_count, 32'd4);

    // Retire counter wrap
    force dut.retire_count_q = 32'hFFFF_FFFF;
    exp_retire = 32'hFFFF_FFFF;
    tick();
    release dut.retire_count_q;
    issue(32'h00700493, 32'h0000_0007);
    drain();
    check("retire_wrap", retire_count, 32'd0);
    rs1_addr = 5'd9;
    #1;
    check("x9_last", rs1_data, 32'd7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_writeback_rf.md
# alu_writeback_rf

Write-back end of the 3-stage ALU pipeline. Tracks every issued R-type (0110011) and I-type (0010011) instruction's destination register, and commits the pipeline's `alu_result` into a 32 x 32-bit register file when that instruction's result arrives. It also supplies the two combinational register-file read ports that the decode stage uses, with write-through bypass. It flags read-after-write hazards for the instruction currently being issued.

## Interface
- `XLEN`, 32, data width of the register file and of `alu_result`.
- `WB_LATENCY`, 4, number of cycles from the issue cycle (instruction sampled) to the cycle in which its result is present on `alu_result`. Must be ≥ 2.
- `clk`  in  1  single clock. All state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  `issue_instruction` is valid this cycle.
- `issue_instruction`  in  32  the same instruction word presented to the pipeline's fetch input.
- `alu_result`  in  XLEN  registered result output of the ALU pipeline.
- `rs1_addr`, `rs2_addr`  in  5  read-port addresses.
- `rs1_data`, `rs2_data`  out  XLEN  combinational read data.
- `hazard`  out  1  combinational RAW hazard flag for the instruction being issued.
- `wb_valid`  out  1  registered; a register write was committed in the previous cycle.
- `wb_rd`  out  5  registered; destination of that write.
- `wb_data`  out  XLEN  registered; value written.
- `retire_count`  out  32  registered count of retired ALU instructions.

## Operation
- **Issue decode.**
  - A tag is {valid, we, rd}.
  - valid = `issue_valid` and opcode `[6:0]` ∈ {0110011, 0010011}.
  - rd = `[11:7]`.
  - we = valid and rd ≠ 0.
  - Any other opcode issues a bubble (valid=0).
- **Tag pipe.**
  - Shift register `tag[0..WB_LATENCY-1]`. Each edge: `tag[0]` ← new tag, `tag[i]` ← `tag[i-1]`.
  - `tag[WB_LATENCY-1]` is the commit stage: its instruction's result is on `alu_result` this cycle.
- **Commit** (at the edge ending the commit cycle, when the commit tag is valid):
  - if we: `rf[rd]` ← `alu_result`; `wb_valid`←1, `wb_rd`←rd, `wb_data`←`alu_result`;
  - if not we: `wb_valid`←0, `wb_rd`/`wb_data` hold;
  - `retire_count` += 1 in both cases, wrapping 0xFFFF_FFFF → 0.
- **Idle.** When the commit tag is not valid, `wb_valid`←0.
- **Reads.**
  - `rsN_data` = 0 if `rsN_addr` = 0.
  - Otherwise, if the commit tag has we=1 with rd = `rsN_addr`, return `alu_result` (bypass).
  - Otherwise return `rf[rsN_addr]`.
- **Hazard.**
  - `hazard` = `issue_valid` and the issuing instruction's source matches any `tag[i]`, i ∈ 0..WB_LATENCY-2, with we=1.
  - Sources: rs1 `[19:15]` for both formats; rs2 `[24:20]` for R-type only.
  - Source 0 never matches. The commit stage is excluded because it is covered by bypass.
  - `hazard` is advisory; issue is never blocked internally.
- **Register 0.** x0 is never written.

## Timing
- **Reset** (sampled high at an edge):
  - all tags cleared, all `rf` entries 0;
  - `wb_valid`=0, `wb_rd`=0, `wb_data`=0, `retire_count`=0.
  - Reset has priority over issue and commit in the same cycle.
  - Reset mid-flight drops every in-flight tag with no write.
- **Instruction issued in cycle k:**
  - result is sampled from `alu_result` in cycle k+WB_LATENCY;
  - `rf` is updated and `wb_*`/`retire_count` are visible in cycle k+WB_LATENCY+1.
- **Throughput.** One issue per cycle; back-to-back commits to the same rd each write in order.
- **Read/write collision.** A read in the commit cycle sees the new value via bypass. A read in the following cycle sees it from `rf`.
- **Combinational outputs.** `rs1_data`, `rs2_data` and `hazard` have no pipeline latency.

## Test plan
- **Reset.** Assert `reset` for 2 cycles, then sweep `rs1_addr`/`rs2_addr` 0..31 -> all data 0, `wb_valid`=0, `retire_count`=0.
- **Basic write-back.** Issue `add x5,x1,x2` (0x002082B3) in cycle 0; drive `alu_result`=0x1234_5678 in cycle 4.
  - Cycle 4 with `rs1_addr`=5 -> `rs1_data`=0x1234_5678 (bypass).
  - Cycle 5 -> `wb_valid`=1, `wb_rd`=5, `wb_data`=0x1234_5678, `retire_count`=1, `rs2_addr`=5 reads 0x1234_5678.
- **x0 and unsupported opcodes.**
  - Issue `addi x0,x0,5` (0x00500013) in cycle 0 -> cycle 5: `wb_valid`=0, `retire_count`=1, x0 reads 0.
  - Issue `lw x1,0(x0)` (0x00002083) -> no write, `retire_count` unchanged.
- **Hazard.** Issue `addi x3,x0,1` (0x00100193) in cycle 0.
  - Present `add x4,x3,x3` (0x00318233) with `issue_valid` in cycle 1 -> `hazard`=1.
  - Same word in cycle 3 -> `hazard`=1; in cycle 4 -> `hazard`=0.
  - I-type word with rs2 field = 3 but rs1 = 0 in cycle 1 -> `hazard`=0.
- **Reset mid-flight.** Issue `add x7,x1,x2` in cycle 0; assert `reset` in cycle 2; drive `alu_result`=0xDEAD_BEEF in cycle 4 -> x7 reads 0, `wb_valid`=0 in cycle 5, `retire_count`=0.
- **Back-to-back and wrap.**
  - Issue 4 consecutive `addi x9` instructions with results 1,2,3,4 -> `wb_data` 1,2,3,4 on consecutive cycles; x9 ends at 4.
  - Force `retire_count` to 0xFFFF_FFFF via 2^32-1 retires (or a bench hierarchical deposit), retire one more -> 0.
